// File: rtl/hamming_byte_encoder_if.sv
// Byte-in / codeword-out streaming bus for the Hamming(7,4) byte encoder.
// CW_W is 8 when HAMMING_SECDED_EN is defined (extra overall-parity bit), else 7.
interface hamming_byte_encoder_if #(
  parameter int unsigned CNT_W = 16,
`ifdef HAMMING_SECDED_EN
  parameter int unsigned CW_W  = 8
`else
  parameter int unsigned CW_W  = 7
`endif
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [CW_W-1:0]  out_code;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [CNT_W-1:0] byte_cnt;

  // Source/sink side: feeds bytes, consumes codewords.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_code, out_valid, out_last, byte_cnt
  );

  // Encoder side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_code, out_valid, out_last, byte_cnt
  );
endinterface

// File: rtl/hamming_byte_encoder.sv
// Streaming Hamming(7,4) encoder: one byte in, two codewords out, one byte per two clocks.
// Define HAMMING_SECDED_EN to append an even overall-parity bit as out_code[7].
module hamming_byte_encoder #(
  parameter bit          LSN_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input logic                   clk,
  input logic                   rst,
  hamming_byte_encoder_if.slave bus
);

`ifdef HAMMING_SECDED_EN
  localparam int unsigned CW_W = 8;
`else
  localparam int unsigned CW_W = 7;
`endif

  typedef enum logic [1:0] {StEmpty, StFirst, StSecond} state_e;

  state_e           state_q, state_d;
  logic [7:0]       byte_q;
  logic [CNT_W-1:0] byte_cnt_q;

  logic             load;
  logic             cnt_inc;
  logic             in_ready;
  logic             out_valid;
  logic             out_last;
  logic [3:0]       nibble;
  logic [6:0]       code7;
  logic [CW_W-1:0]  out_code;

  // Bit order {d3,d2,d1,p3,d0,p2,p1} matches the link's decoder.
  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      byte_q     <= 8'h00;
      byte_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) byte_q <= bus.in_data;
      if (cnt_inc) byte_cnt_q <= byte_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    cnt_inc   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    nibble    = 4'h0;
    unique case (state_q)
      StEmpty: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = StFirst;
        end
      end
      StFirst: begin
        out_valid = 1'b1;
        nibble    = LSN_FIRST ? byte_q[3:0] : byte_q[7:4];
        if (bus.out_ready) state_d = StSecond;
      end
      StSecond: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        nibble    = LSN_FIRST ? byte_q[7:4] : byte_q[3:0];
        // Accepting during the final handshake keeps the stream bubble-free.
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          cnt_inc = 1'b1;
          if (bus.in_valid) begin
            load    = 1'b1;
            state_d = StFirst;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  assign code7 = out_valid ? enc(nibble) : 7'h00;

`ifdef HAMMING_SECDED_EN
  assign out_code = {^code7, code7};
`else
  assign out_code = code7;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_code  = out_code;
  assign bus.byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_hamming_byte_encoder.sv
// Directed self-checking bench for hamming_byte_encoder (both nibble orders).
// Expected codewords are hand-computed; decode checks use an independent syndrome model.
module tb_hamming_byte_encoder;

`ifdef HAMMING_SECDED_EN
  localparam int unsigned CW_W = 8;
`else
  localparam int unsigned CW_W = 7;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt_a = 0;

  always #5 clk = ~clk;

  hamming_byte_encoder_if #(.CNT_W(16)) bus_a ();
  hamming_byte_encoder_if #(.CNT_W(16)) bus_b ();

  hamming_byte_encoder #(.LSN_FIRST(1'b1), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  hamming_byte_encoder #(.LSN_FIRST(1'b0), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Expected on-wire codeword from a hand-computed 7-bit code.
  function automatic logic [CW_W-1:0] wire_code(input logic [6:0] c);
`ifdef HAMMING_SECDED_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  // Decoder model: {s3,s2,s1} is the 1-based position of a single flipped bit.
  function automatic logic [2:0] syndrome(input logic [6:0] c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #2;
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_last !== 1'b0 || bus_a.out_code !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b last=%b code=%h, required 0 0 0",
               bus_a.out_valid, bus_a.out_last, bus_a.out_code);
    end
    n_checks++;
    if (bus_a.byte_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d, required 0", bus_a.byte_cnt);
    end
    n_checks++;
    if (bus_a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", bus_a.in_ready);
    end
    tick();
  endtask

  task automatic test_single_byte();
    bus_a.in_data = 8'hB4; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    #2;
    n_checks++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: in_ready=%b out_valid=%b, required 1 0",
               bus_a.in_ready, bus_a.out_valid);
    end
    tick();
    bus_a.in_valid = 1'b0;
    #2;
    n_checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_code !== wire_code(7'h2A) ||
        bus_a.out_last !== 1'b0 || bus_a.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_first: valid=%b code=%h last=%b in_ready=%b, required 1 %h 0 0",
               bus_a.out_valid, bus_a.out_code, bus_a.out_last, bus_a.in_ready,
               wire_code(7'h2A));
    end
    tick();
    #2;
    n_checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_code !== wire_code(7'h55) ||
        bus_a.out_last !== 1'b1 || bus_a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_second: valid=%b code=%h last=%b in_ready=%b, required 1 %h 1 1",
               bus_a.out_valid, bus_a.out_code, bus_a.out_last, bus_a.in_ready,
               wire_code(7'h55));
    end
    tick();
    exp_cnt_a++;
    #2;
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.byte_cnt !== 16'(exp_cnt_a)) begin
      n_fail++;
      $display("FAIL single_done: valid=%b cnt=%0d, required 0 %0d",
               bus_a.out_valid, bus_a.byte_cnt, exp_cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [6:0] codes [6];
    bytes = '{8'h00, 8'hFF, 8'h11};
    codes = '{7'h00, 7'h00, 7'h7F, 7'h7F, 7'h07, 7'h07};
    bus_a.in_data = bytes[0]; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      // Upstream presents the next byte immediately and holds it until accepted.
      if (i < 4) begin
        bus_a.in_data  = bytes[i / 2 + 1];
        bus_a.in_valid = 1'b1;
      end else begin
        bus_a.in_valid = 1'b0;
      end
      #2;
      n_checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_code !== wire_code(codes[i]) ||
          bus_a.out_last !== 1'(i % 2) || bus_a.in_ready !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: valid=%b code=%h last=%b in_ready=%b, required 1 %h %b %b",
                 i, bus_a.out_valid, bus_a.out_code, bus_a.out_last, bus_a.in_ready,
                 wire_code(codes[i]), 1'(i % 2), 1'(i % 2));
      end
      tick();
    end
    exp_cnt_a += 3;
    #2;
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.byte_cnt !== 16'(exp_cnt_a)) begin
      n_fail++;
      $display("FAIL b2b_done: valid=%b cnt=%0d, required 0 %0d",
               bus_a.out_valid, bus_a.byte_cnt, exp_cnt_a);
    end
  endtask

  task automatic test_msn_first();
    bus_b.in_data = 8'hB4; bus_b.in_valid = 1'b1; bus_b.out_ready = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    #2;
    n_checks++;
    if (bus_b.out_code !== wire_code(7'h55) || bus_b.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL msn_first: code=%h last=%b, required %h 0",
               bus_b.out_code, bus_b.out_last, wire_code(7'h55));
    end
    tick();
    #2;
    n_checks++;
    if (bus_b.out_code !== wire_code(7'h2A) || bus_b.out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL msn_second: code=%h last=%b, required %h 1",
               bus_b.out_code, bus_b.out_last, wire_code(7'h2A));
    end
    tick();
    #2;
    n_checks++;
    if (bus_b.out_valid !== 1'b0 || bus_b.byte_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL msn_done: valid=%b cnt=%0d, required 0 1", bus_b.out_valid, bus_b.byte_cnt);
    end
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    bus_a.in_data = 8'h3C; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_a.out_ready = (i == 5);
      // A stray byte offered while stalled must not be captured.
      bus_a.in_data = 8'hE7; bus_a.in_valid = (i == 2);
      #2;
      n_checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_code !== wire_code(7'h61) ||
          bus_a.out_last !== 1'b0 || bus_a.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_first%0d: valid=%b code=%h last=%b in_ready=%b, required 1 %h 0 0",
                 i, bus_a.out_valid, bus_a.out_code, bus_a.out_last, bus_a.in_ready,
                 wire_code(7'h61));
      end
      if (bus_a.out_valid && bus_a.out_ready) xfers++;
      tick();
    end
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.out_ready = (i == 3);
      #2;
      n_checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_code !== wire_code(7'h1E) ||
          bus_a.out_last !== 1'b1 || bus_a.in_ready !== bus_a.out_ready) begin
        n_fail++;
        $display("FAIL bp_second%0d: valid=%b code=%h last=%b in_ready=%b, required 1 %h 1 %b",
                 i, bus_a.out_valid, bus_a.out_code, bus_a.out_last, bus_a.in_ready,
                 wire_code(7'h1E), bus_a.out_ready);
      end
      if (bus_a.out_valid && bus_a.out_ready) xfers++;
      tick();
    end
    bus_a.out_ready = 1'b1;
    exp_cnt_a++;
    for (int i = 0; i < 2; i++) begin
      #2;
      if (bus_a.out_valid && bus_a.out_ready) xfers++;
      tick();
    end
    n_checks++;
    if (xfers != 2 || bus_a.byte_cnt !== 16'(exp_cnt_a)) begin
      n_fail++;
      $display("FAIL bp_count: transfers=%0d cnt=%0d, required 2 %0d",
               xfers, bus_a.byte_cnt, exp_cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    bus_a.in_data = 8'h5A; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    bus_a.out_ready = 1'b0;
    #2;
    n_checks++;
    if (bus_a.out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: last=%b, required 1", bus_a.out_last);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt_a = 0;
    #2;
    n_checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.byte_cnt !== 16'd0 || bus_a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_post: valid=%b cnt=%0d in_ready=%b, required 0 0 1",
               bus_a.out_valid, bus_a.byte_cnt, bus_a.in_ready);
    end
    bus_a.in_data = 8'hB4; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    #2;
    n_checks++;
    if (bus_a.out_code !== wire_code(7'h2A) || bus_a.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_first: code=%h last=%b, required %h 0",
               bus_a.out_code, bus_a.out_last, wire_code(7'h2A));
    end
    tick();
    #2;
    n_checks++;
    if (bus_a.out_code !== wire_code(7'h55) || bus_a.out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_second: code=%h last=%b, required %h 1",
               bus_a.out_code, bus_a.out_last, wire_code(7'h55));
    end
    tick();
    exp_cnt_a++;
    #2;
    n_checks++;
    if (bus_a.byte_cnt !== 16'(exp_cnt_a)) begin
      n_fail++;
      $display("FAIL rstmid_cnt: got %0d, required %0d", bus_a.byte_cnt, exp_cnt_a);
    end
  endtask

  task automatic test_decode_all_nibbles();
    logic [3:0] nib;
    logic [6:0] cw;
    logic [6:0] flipped;
    logic [3:0] data;
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus_a.in_data = {4'(2 * k + 1), 4'(2 * k)}; bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      for (int h = 0; h < 2; h++) begin
        #2;
        nib  = 4'(2 * k + h);
        cw   = bus_a.out_code[6:0];
        data = {cw[6], cw[5], cw[4], cw[2]};
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || data !== nib || syndrome(cw) !== 3'd0) begin
          n_fail++;
          $display("FAIL decode_nib%0d: valid=%b data=%h syndrome=%0d, required 1 %h 0",
                   nib, bus_a.out_valid, data, syndrome(cw), nib);
        end
`ifdef HAMMING_SECDED_EN
        n_checks++;
        if (^bus_a.out_code !== 1'b0) begin
          n_fail++;
          $display("FAIL parity_nib%0d: code=%h overall parity odd, required even",
                   nib, bus_a.out_code);
        end
`endif
        for (int b = 0; b < 7; b++) begin
          flipped = cw ^ (7'd1 << b);
          n_checks++;
          if (syndrome(flipped) !== 3'(b + 1)) begin
            n_fail++;
            $display("FAIL flip_nib%0d_bit%0d: error_position=%0d, required %0d",
                     nib, b, syndrome(flipped), b + 1);
          end
        end
        tick();
      end
    end
  endtask

  initial begin
    bus_a.in_data = 8'h00; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_data = 8'h00; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_msn_first();
    test_backpressure();
    test_reset_mid();
    test_decode_all_nibbles();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
